bcd_counter_n: RTL and testbench
================================

// Module: bcd_counter_n
// PURPOSE
//  Parametrised synchronous N-digit BCD counter for latency/frame measurement.
//  Counts up or down on single-cycle enables in the clock domain.
//  Supports parallel load, clear, wrap or saturate mode, a snapshot register and overflow flags.
//  Sits between measurement control logic and the BCD-to-display/OSD path.
// PARAMETERS
//  DIGITS    6  number of BCD digits (1..8); count width = 4*DIGITS
//  SATURATE  0  0: wrap 99..9->0 / 0->99..9; 1: hold at 99..9 / 0
// PORTS
//  clock        in   1         system clock, all logic on rising edge
//  reset        in   1         synchronous, active-high reset
//  clear        in   1         synchronous clear of count (not of snapshot)
//  load         in   1         load load_value into count
//  load_value   in   4*DIGITS  BCD value to load
//  inc          in   1         count up by one this cycle
//  dec          in   1         count down by one this cycle
//  capture      in   1         copy current count into snapshot
//  bcdcount     out  4*DIGITS  current count, digit 0 = bits [3:0] (least significant)
//  snapshot     out  4*DIGITS  last captured count
//  snap_valid   out  1         one-cycle pulse, cycle after capture
//  carry_out    out  1         one-cycle pulse on wrap/saturate-hit boundary
//  overflow     out  1         sticky flag, set on any up-wrap/up-saturate
//  underflow    out  1         sticky flag, set on any down-wrap/down-saturate
// BEHAVIOUR
//  - Reset: all outputs 0. Reset is synchronous and active-high on clock, with the highest priority.
//  - Priority per cycle: reset > clear > load > (inc xor dec). inc&dec both high = no change.
//  - clear: count <- 0; overflow and underflow <- 0; carry_out 0.
//  - load: count <- load_value. Any loaded digit >9 is forced to 9.
//    load does not touch the sticky flags.
//  - inc: digit0 +1. Digit at 9 -> 0 and carries into the next digit (ripple in the same cycle).
//    Digit k increments only if digits 0..k-1 are all 9.
//  - dec: digit0 -1. Digit at 0 -> 9 and borrows into the next digit.
//  - Up boundary (all digits 9, inc):
//    - SATURATE=0: count -> 0.
//    - SATURATE=1: count stays all-9.
//    - Either mode: carry_out=1 next cycle; overflow set.
//  - Down boundary (all digits 0, dec):
//    - SATURATE=0: count -> all-9.
//    - SATURATE=1: count stays 0.
//    - Either mode: carry_out=1 next cycle; underflow set.
//  - Latency: bcdcount reflects an inc/dec/load/clear one clock after the enable is sampled.
//  - carry_out is registered and high for exactly one cycle per boundary event.
//    It is 0 in every other cycle.
//  - capture:
//    - snapshot <- bcdcount value present before this cycle's update; snap_valid=1 next cycle.
//    - capture together with inc: snapshot gets the pre-increment value.
//    - capture together with clear or load: snapshot gets the pre-clear/pre-load value.
//  - Reset mid-operation: count, snapshot and all flags return to 0 on the next edge.
//    No pulse outputs are asserted in the cycle after reset.
//  - Count is always legal BCD (every digit 0..9) in all reachable states.
// TESTING
//  1. DIGITS=6: reset, 1000 inc pulses -> bcdcount=24'h001000; carry_out never high.
//  2. DIGITS=6, SATURATE=0: load 24'h999998, inc x2 -> 999999, then 000000.
//     carry_out high one cycle; overflow=1 until clear.
//  3. DIGITS=6, SATURATE=1: load 24'h000001, dec x3 -> 000000 held.
//     carry_out pulses once per dec at 0 (2 pulses); underflow=1.
//  4. Load 24'hF3A912 -> bcdcount=24'h939912. inc&dec together -> unchanged.
//     clear with load -> 000000.
//  5. Count at 24'h000457, capture+inc same cycle -> snapshot=000457, bcdcount=000458.
//     snap_valid high exactly one cycle.
//  6. DIGITS=2: 250 inc from reset -> bcdcount=8'h50, carry_out pulsed twice.
//     Assert reset mid-count -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bcd_counter_n_if.sv
// Interface bundling the control inputs and status outputs of bcd_counter_n.
//   master : measurement control side, drives clear/load/load_value/inc/dec/capture
//            and observes bcdcount/snapshot/snap_valid/carry_out/overflow/underflow
//   slave  : counter side, the mirror image
// DIGITS must match the DIGITS of the attached counter (bus width = 4*DIGITS).
interface bcd_counter_n_if #(
    parameter int unsigned DIGITS = 6
);
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  inc;
    logic                  dec;
    logic                  capture;
    logic [4*DIGITS-1:0]   bcdcount;
    logic [4*DIGITS-1:0]   snapshot;
    logic                  snap_valid;
    logic                  carry_out;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, load, load_value, inc, dec, capture,
        input  bcdcount, snapshot, snap_valid, carry_out, overflow, underflow
    );

    modport slave (
        input  clear, load, load_value, inc, dec, capture,
        output bcdcount, snapshot, snap_valid, carry_out, overflow, underflow
    );
endinterface

// File: rtl/bcd_counter_n.sv
// Parametrised synchronous N-digit BCD up/down counter with parallel load,
// clear, wrap or saturate behaviour, snapshot register and boundary flags.
// Ports:
//   clock : system clock, all state on rising edge
//   reset : synchronous active-high reset, highest priority
//   bus   : bcd_counter_n_if.slave carrying
//           clear, load, load_value, inc, dec, capture (inputs)
//           bcdcount, snapshot, snap_valid, carry_out, overflow, underflow (outputs)
// Parameters:
//   DIGITS   : number of BCD digits (1..8), digit 0 in bits [3:0]
//   SATURATE : 0 = wrap at the boundaries, 1 = hold at all-9 / zero
module bcd_counter_n #(
    parameter int unsigned DIGITS   = 6,
    parameter bit          SATURATE = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    bcd_counter_n_if.slave bus
);
    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] snapshot_q, snapshot_d;
    logic         snap_valid_q, snap_valid_d;
    logic         carry_q, carry_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;

    // Per-digit helpers: incremented, decremented and load-sanitised values.
    logic [W-1:0] inc_val, dec_val, load_val;
    logic         all_nine, all_zero;
    logic         ripple_up, ripple_dn;
    logic [3:0]   digit, ld_digit;

    always_comb begin
        inc_val   = '0;
        dec_val   = '0;
        load_val  = '0;
        all_nine  = 1'b1;
        all_zero  = 1'b1;
        ripple_up = 1'b1;
        ripple_dn = 1'b1;
        digit     = '0;
        ld_digit  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (digit != 4'd9) all_nine = 1'b0;
            if (digit != 4'd0) all_zero = 1'b0;

            // A digit moves only while every lower digit rolled over.
            if (ripple_up) begin
                if (digit == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digit + 4'd1;
                    ripple_up         = 1'b0;
                end
            end else begin
                inc_val[4*i +: 4] = digit;
            end

            if (ripple_dn) begin
                if (digit == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digit - 4'd1;
                    ripple_dn         = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = digit;
            end

            // Illegal BCD nibbles are clamped to 9 so the count stays legal.
            ld_digit = bus.load_value[4*i +: 4];
            load_val[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
        end
    end

    always_comb begin
        count_d      = count_q;
        snapshot_d   = snapshot_q;
        snap_valid_d = 1'b0;
        carry_d      = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        // Snapshot always sees the count from before this cycle's update.
        if (bus.capture) begin
            snapshot_d   = count_q;
            snap_valid_d = 1'b1;
        end

        if (bus.clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (bus.load) begin
            count_d = load_val;
        end else if (bus.inc && !bus.dec) begin
            if (all_nine) begin
                carry_d    = 1'b1;
                overflow_d = 1'b1;
                count_d    = SATURATE ? count_q : '0;
            end else begin
                count_d = inc_val;
            end
        end else if (bus.dec && !bus.inc) begin
            if (all_zero) begin
                carry_d     = 1'b1;
                underflow_d = 1'b1;
                count_d     = SATURATE ? count_q : dec_val;
            end else begin
                count_d = dec_val;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q      <= '0;
            snapshot_q   <= '0;
            snap_valid_q <= 1'b0;
            carry_q      <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            snapshot_q   <= snapshot_d;
            snap_valid_q <= snap_valid_d;
            carry_q      <= carry_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.bcdcount   = count_q;
    assign bus.snapshot   = snapshot_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.carry_out  = carry_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n. Three counters share one stimulus
// stream: A (6 digits, wrap), B (6 digits, saturate), C (2 digits, wrap).
// Each is checked every cycle against an integer-valued reference model;
// a table of hand-derived vectors and directed sequences cover the corners.
module tb_bcd_counter_n;
    logic clock;
    logic reset;

    bcd_counter_n_if #(.DIGITS(6)) if_a();
    bcd_counter_n_if #(.DIGITS(6)) if_b();
    bcd_counter_n_if #(.DIGITS(2)) if_c();

    bcd_counter_n #(.DIGITS(6), .SATURATE(1'b0)) u_a (.clock(clock), .reset(reset), .bus(if_a));
    bcd_counter_n #(.DIGITS(6), .SATURATE(1'b1)) u_b (.clock(clock), .reset(reset), .bus(if_b));
    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0)) u_c (.clock(clock), .reset(reset), .bus(if_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned carries_a, carries_b, carries_c;

    typedef struct {
        longint unsigned cnt;
        longint unsigned snap;
        bit              sv;
        bit              carry;
        bit              ovf;
        bit              unf;
    } mstate_t;

    mstate_t m_a, m_b, m_c;

    // Reference model: the count is held as a plain integer 0 .. 10^digits-1.
    function automatic mstate_t mstep(mstate_t s, int unsigned digits, bit sat,
                                      bit rst, bit clr, bit ld, logic [31:0] lv,
                                      bit inc, bit dec, bit cap);
        mstate_t n;
        longint unsigned maxv = 1;
        longint unsigned v    = 0;
        logic [3:0] nib;
        for (int unsigned i = 0; i < digits; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        n = s;
        n.sv = 0;
        n.carry = 0;
        if (rst) begin
            n.cnt = 0; n.snap = 0; n.ovf = 0; n.unf = 0;
            return n;
        end
        if (cap) begin
            n.snap = s.cnt;
            n.sv = 1;
        end
        if (clr) begin
            n.cnt = 0; n.ovf = 0; n.unf = 0;
        end else if (ld) begin
            for (int i = int'(digits) - 1; i >= 0; i--) begin
                nib = lv[4*i +: 4];
                if (nib > 4'd9) nib = 4'd9;
                v = v * 10 + longint'(nib);
            end
            n.cnt = v;
        end else if (inc && !dec) begin
            if (s.cnt == maxv) begin
                n.carry = 1; n.ovf = 1;
                n.cnt = sat ? maxv : 0;
            end else n.cnt = s.cnt + 1;
        end else if (dec && !inc) begin
            if (s.cnt == 0) begin
                n.carry = 1; n.unf = 1;
                n.cnt = sat ? 0 : maxv;
            end else n.cnt = s.cnt - 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] int2bcd(longint unsigned v, int unsigned digits);
        logic [31:0] r = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_models();
        check("A.count", 32'(if_a.bcdcount), int2bcd(m_a.cnt, 6));
        check("A.snap",  32'(if_a.snapshot), int2bcd(m_a.snap, 6));
        check("A.flags", {28'd0, if_a.snap_valid, if_a.carry_out, if_a.overflow, if_a.underflow},
                         {28'd0, m_a.sv, m_a.carry, m_a.ovf, m_a.unf});
        check("B.count", 32'(if_b.bcdcount), int2bcd(m_b.cnt, 6));
        check("B.snap",  32'(if_b.snapshot), int2bcd(m_b.snap, 6));
        check("B.flags", {28'd0, if_b.snap_valid, if_b.carry_out, if_b.overflow, if_b.underflow},
                         {28'd0, m_b.sv, m_b.carry, m_b.ovf, m_b.unf});
        check("C.count", 32'(if_c.bcdcount), int2bcd(m_c.cnt, 2));
        check("C.snap",  32'(if_c.snapshot), int2bcd(m_c.snap, 2));
        check("C.flags", {28'd0, if_c.snap_valid, if_c.carry_out, if_c.overflow, if_c.underflow},
                         {28'd0, m_c.sv, m_c.carry, m_c.ovf, m_c.unf});
    endtask

    // One clock: drive inputs, advance models, sample 1 time unit after the edge.
    task automatic step(bit rst, bit clr, bit ld, logic [31:0] lv, bit inc, bit dec, bit cap);
        mstate_t na, nb, nc;
        reset = rst;
        if_a.clear = clr; if_a.load = ld; if_a.load_value = lv[23:0];
        if_a.inc = inc;   if_a.dec = dec; if_a.capture = cap;
        if_b.clear = clr; if_b.load = ld; if_b.load_value = lv[23:0];
        if_b.inc = inc;   if_b.dec = dec; if_b.capture = cap;
        if_c.clear = clr; if_c.load = ld; if_c.load_value = lv[7:0];
        if_c.inc = inc;   if_c.dec = dec; if_c.capture = cap;
        na = mstep(m_a, 6, 1'b0, rst, clr, ld, lv, inc, dec, cap);
        nb = mstep(m_b, 6, 1'b1, rst, clr, ld, lv, inc, dec, cap);
        nc = mstep(m_c, 2, 1'b0, rst, clr, ld, lv, inc, dec, cap);
        @(posedge clock);
        #1;
        m_a = na; m_b = nb; m_c = nc;
        cmp_models();
        carries_a += int'(if_a.carry_out);
        carries_b += int'(if_b.carry_out);
        carries_c += int'(if_c.carry_out);
    endtask

    typedef struct {
        bit          clr, ld;
        logic [23:0] lv;
        bit          inc, dec, cap;
        logic [23:0] e_cnt, e_snap;
        bit          e_sv, e_c, e_o, e_u;
    } vec_t;

    vec_t tbl[16];

    initial begin
        m_a = '{default:0}; m_b = '{default:0}; m_c = '{default:0};
        carries_a = 0; carries_b = 0; carries_c = 0;

        // Expected behaviour of counter A (6 digits, wrap), hand-derived.
        //            clr ld  lv          inc dec cap  cnt         snap        sv c  o  u
        tbl[0]  = '{1, 0, 24'h000000, 0, 0, 0, 24'h000000, 24'h000000, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 24'h999998, 0, 0, 0, 24'h999998, 24'h000000, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 24'h000000, 1, 0, 0, 24'h999999, 24'h000000, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 24'h000000, 1, 0, 0, 24'h000000, 24'h000000, 0, 1, 1, 0};
        tbl[4]  = '{0, 0, 24'h000000, 0, 0, 0, 24'h000000, 24'h000000, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 24'hF3A912, 0, 0, 0, 24'h939912, 24'h000000, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 24'h000000, 1, 1, 0, 24'h939912, 24'h000000, 0, 0, 1, 0};
        tbl[7]  = '{1, 1, 24'h123456, 0, 0, 0, 24'h000000, 24'h000000, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 24'h000457, 0, 0, 0, 24'h000457, 24'h000000, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 24'h000000, 1, 0, 1, 24'h000458, 24'h000457, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 24'h000000, 0, 0, 0, 24'h000458, 24'h000457, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 24'h000000, 0, 1, 0, 24'h000457, 24'h000457, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 24'h000100, 0, 0, 1, 24'h000100, 24'h000457, 1, 0, 0, 0};
        tbl[13] = '{1, 0, 24'h000000, 0, 0, 1, 24'h000000, 24'h000100, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 24'h000000, 0, 1, 0, 24'h999999, 24'h000100, 0, 1, 0, 1};
        tbl[15] = '{0, 0, 24'h000000, 0, 0, 0, 24'h999999, 24'h000100, 0, 0, 0, 1};

        reset = 1'b1;
        if_a.clear = 0; if_a.load = 0; if_a.load_value = '0; if_a.inc = 0; if_a.dec = 0; if_a.capture = 0;
        if_b.clear = 0; if_b.load = 0; if_b.load_value = '0; if_b.inc = 0; if_b.dec = 0; if_b.capture = 0;
        if_c.clear = 0; if_c.load = 0; if_c.load_value = '0; if_c.inc = 0; if_c.dec = 0; if_c.capture = 0;
        @(posedge clock);
        #1;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset.a_all", {if_a.bcdcount, if_a.snap_valid, if_a.carry_out, if_a.overflow, if_a.underflow}, 32'd0);
        check("reset.a_snap", 32'(if_a.snapshot), 32'd0);

        // 1000 increments from zero
        carries_a = 0;
        for (int i = 0; i < 1000; i++) step(0, 0, 0, 0, 1, 0, 0);
        check("inc1000.count", 32'(if_a.bcdcount), 32'h001000);
        check("inc1000.carries", carries_a, 0);
        check("inc1000.c_count", 32'(if_c.bcdcount), 32'h00);

        // Table vectors against counter A
        for (int i = 0; i < 16; i++) begin
            step(0, tbl[i].clr, tbl[i].ld, 32'(tbl[i].lv), tbl[i].inc, tbl[i].dec, tbl[i].cap);
            check($sformatf("tbl%0d.count", i), 32'(if_a.bcdcount), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d.snap", i), 32'(if_a.snapshot), 32'(tbl[i].e_snap));
            check($sformatf("tbl%0d.flags", i),
                  {28'd0, if_a.snap_valid, if_a.carry_out, if_a.overflow, if_a.underflow},
                  {28'd0, tbl[i].e_sv, tbl[i].e_c, tbl[i].e_o, tbl[i].e_u});
        end

        // Saturating down boundary on counter B
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h000001, 0, 0, 0);
        carries_b = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("sat_dn.count", 32'(if_b.bcdcount), 32'h000000);
        check("sat_dn.carries", carries_b, 2);
        check("sat_dn.underflow", 32'(if_b.underflow), 32'd1);
        check("sat_dn.carry_idle", 32'(if_b.carry_out), 32'd0);

        // Saturating up boundary on counter B
        step(0, 0, 1, 32'h999999, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("sat_up.count", 32'(if_b.bcdcount), 32'h999999);
        check("sat_up.flags", {if_b.carry_out, if_b.overflow}, 32'd3);

        // Two-digit counter: 250 increments, then reset mid-count
        step(1, 0, 0, 0, 0, 0, 0);
        carries_c = 0;
        for (int i = 0; i < 250; i++) step(0, 0, 0, 0, 1, 0, 0);
        check("c250.count", 32'(if_c.bcdcount), 32'h50);
        check("c250.carries", carries_c, 2);
        for (int i = 0; i < 49; i++) step(0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        check("c_rst.all", {if_c.bcdcount, if_c.snapshot, if_c.snap_valid, if_c.carry_out, if_c.overflow, if_c.underflow}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("c_rst.no_pulse", {if_c.snap_valid, if_c.carry_out}, 32'd0);

        // Randomised traffic, biased toward the boundaries
        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_clr, r_ld, r_inc, r_dec, r_cap;
            logic [31:0] lv;
            int unsigned sel;
            r_rst = ($urandom_range(0, 299) == 0);
            r_clr = ($urandom_range(0, 79) == 0);
            r_ld  = ($urandom_range(0, 24) == 0);
            r_inc = $urandom_range(0, 1) == 1;
            r_dec = $urandom_range(0, 2) == 0;
            r_cap = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0: lv = 32'h00999997;
                1: lv = 32'h00000002;
                default: lv = $urandom;
            endcase
            step(r_rst, r_clr, r_ld, lv, r_inc, r_dec, r_cap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
